// File: rtl/alarm_ctrl.sv
// alarm_ctrl: supervisory controller for the lamp-sequence alarm detector.
// Arms/disarms the detector (holding it in reset while not detecting), sounds
// a timed siren on a completed lamp sequence, latches the alarm until
// acknowledged and counts alarm events (saturating).
//
// Ports:
//   clk         clock, all state changes on posedge
//   reset       synchronous, active-high, top priority
//   arm_req     request to arm; honoured only in DISARMED
//   disarm_req  request to disarm; honoured in every state
//   ack         operator acknowledge; honoured only in SIREN and LATCHED
//   alarm_bit   detector output; 1 = lamp sequence completed
//   det_reset   detector reset; 1 holds the detector idle
//   siren       audible alarm
//   armed       detection active (ARMED, SIREN, LATCHED)
//   state_code  current state encoding
//   event_cnt   number of ARMED->SIREN transitions, saturating
module alarm_ctrl #(
  parameter int unsigned ARM_DELAY    = 4,
  parameter int unsigned SIREN_CYCLES = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm_req,
  input  logic             disarm_req,
  input  logic             ack,
  input  logic             alarm_bit,
  output logic             det_reset,
  output logic             siren,
  output logic             armed,
  output logic [2:0]       state_code,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int unsigned MaxCycles = (ARM_DELAY > SIREN_CYCLES) ? ARM_DELAY : SIREN_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef enum logic [2:0] {
    StDisarmed = 3'd0,
    StArming   = 3'd1,
    StArmed    = 3'd2,
    StSiren    = 3'd3,
    StLatched  = 3'd4,
    StRearm    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StDisarmed;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; disarm_req overrides everything else.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    if (disarm_req) begin
      state_d = StDisarmed;
      timer_d = '0;
    end else begin
      case (state_q)
        StDisarmed: begin
          if (arm_req) begin
            state_d = StArming;
            timer_d = TimerW'(ARM_DELAY - 1);
          end
        end
        StArming: begin
          if (timer_q != '0) timer_d = timer_q - 1'b1;
          else               state_d = StArmed;
        end
        StArmed: begin
          if (alarm_bit) begin
            state_d = StSiren;
            timer_d = TimerW'(SIREN_CYCLES - 1);
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
        end
        StSiren: begin
          // ack wins over timer expiry
          if (ack)                  state_d = StRearm;
          else if (timer_q != '0)   timer_d = timer_q - 1'b1;
          else                      state_d = StLatched;
        end
        StLatched: begin
          if (ack) state_d = StRearm;
        end
        StRearm: begin
          // One-cycle detector reset flushes any stale alarm_bit.
          state_d = StArmed;
        end
        default: begin
          state_d = StDisarmed;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    det_reset = 1'b0;
    siren     = 1'b0;
    armed     = 1'b0;
    case (state_q)
      StDisarmed, StArming, StRearm: det_reset = 1'b1;
      StArmed, StLatched:            armed     = 1'b1;
      StSiren: begin
        siren = 1'b1;
        armed = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_code = state_q;
  assign event_cnt  = cnt_q;

endmodule
